// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - CALL/RET/IRQ/RETI sequencer and depth guard in front of stack_module
module stack_ctrl #(
    parameter int WIDTH = 10,
    parameter int NWORDS = 16,
    localparam int DW = $clog2(NWORDS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             call_req,
    input  logic             ret_req,
    input  logic             irq_req,
    input  logic             reti_req,
    input  logic             irq_en,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] flags_in,
    input  logic [WIDTH-1:0] stack_dout,
    output logic             we_stack,
    output logic             s_pushpop,
    output logic             s_interruption,
    output logic [WIDTH-1:0] stack_din,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_out,
    output logic             flags_load,
    output logic [WIDTH-1:0] flags_out,
    output logic             irq_ack,
    output logic             busy,
    output logic             overflow,
    output logic             underflow,
    output logic [DW-1:0]    depth
);

    localparam logic [DW-1:0] DEPTH_FULL = DW'(NWORDS);
    localparam logic [DW-1:0] DEPTH_IRQ  = DW'(NWORDS - 2);
    localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
    localparam logic [DW-1:0] DEPTH_TWO  = DW'(2);

    typedef enum logic [2:0] {
        IDLE,
        CALL_PUSH,
        RET_POP,
        IRQ_PUSH_PC,
        IRQ_PUSH_FLG,
        RETI_POP_FLG,
        RETI_POP_PC
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             set_ovf;
    logic             set_unf;
    logic             capture;
    logic [WIDTH-1:0] flg_hold;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fixed-priority arbitration with depth admission; a refused winner blocks lower requests
    always_comb begin
        next_state = IDLE;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (irq_req && irq_en) begin
                    if (depth <= DEPTH_IRQ) begin
                        next_state = IRQ_PUSH_PC;
                        capture    = 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end else if (reti_req) begin
                    if (depth >= DEPTH_TWO) next_state = RETI_POP_FLG;
                    else                    set_unf    = 1'b1;
                end else if (call_req) begin
                    if (depth < DEPTH_FULL) begin
                        next_state = CALL_PUSH;
                        capture    = 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end else if (ret_req) begin
                    if (depth >= DEPTH_ONE) next_state = RET_POP;
                    else                    set_unf    = 1'b1;
                end
            end
            IRQ_PUSH_PC:  next_state = IRQ_PUSH_FLG;
            RETI_POP_FLG: next_state = RETI_POP_PC;
            default:      next_state = IDLE;
        endcase
    end

    // Stack command lines registered from the state being entered, so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_stack       <= 1'b0;
            s_pushpop      <= 1'b0;
            s_interruption <= 1'b0;
            busy           <= 1'b0;
        end else begin
            we_stack       <= (next_state != IDLE);
            s_pushpop      <= (next_state inside {RET_POP, RETI_POP_FLG, RETI_POP_PC});
            s_interruption <= (next_state inside {IRQ_PUSH_PC, IRQ_PUSH_FLG,
                                                  RETI_POP_FLG, RETI_POP_PC});
            busy           <= (next_state != IDLE);
        end
    end

    // Push data: pc_in at grant, then the flags word held from the same grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stack_din <= '0;
            flg_hold  <= '0;
        end else if (capture) begin
            stack_din <= pc_in;
            flg_hold  <= flags_in;
        end else if (state == IRQ_PUSH_PC) begin
            stack_din <= flg_hold;
        end
    end

    // Depth tracks each stack cycle as it is issued; admission keeps it in 0..NWORDS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
        end else begin
            case (next_state)
                CALL_PUSH, IRQ_PUSH_PC, IRQ_PUSH_FLG:  depth <= depth + DEPTH_ONE;
                RET_POP, RETI_POP_FLG, RETI_POP_PC:    depth <= depth - DEPTH_ONE;
                default:                               depth <= depth;
            endcase
        end
    end

    // Capture popped words during pop cycles and strobe them out one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out     <= '0;
            flags_out  <= '0;
            pc_load    <= 1'b0;
            flags_load <= 1'b0;
            irq_ack    <= 1'b0;
        end else begin
            if (state == RET_POP || state == RETI_POP_PC) pc_out <= stack_dout;
            if (state == RETI_POP_FLG)                    flags_out <= stack_dout;
            pc_load    <= (state == RET_POP || state == RETI_POP_PC);
            flags_load <= (state == RETI_POP_PC);
            irq_ack    <= (state == IRQ_PUSH_FLG);
        end
    end

    // Sticky errors; a new refusal in the same cycle outranks err_clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_ovf)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (set_unf)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

endmodule
